// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the arbiter requester block.
// Contents:
//   DEF_DATA_W / DEF_DEPTH / DEF_TIMEOUT : default parameter values
//   arb_state_e                          : requester FSM state encoding
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_req_fifo.sv
// -----------------------------------------------------------------------------
// arb_req_fifo
// Synchronous FIFO holding transactions waiting for an arbiter grant.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (control only)
//   push, push_data   : write request and payload (ignored when full)
//   pop               : read request (ignored when empty)
//   head_data         : oldest entry, valid while !empty
//   full, empty       : occupancy flags
//   count             : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & ~empty;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; emptiness is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
// Queues local transactions and requests one port of a round-robin arbiter;
// each grant pulse moves the oldest queued transaction onto the shared bus as
// a single registered beat.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_data      : producer offer; accepted when in_ready is high
//   in_ready              : FIFO not full
//   req                   : registered request line, high only in REQ state
//   grant                 : single-cycle grant pulse from the arbiter
//   bus_valid/bus_data    : one-cycle beat; bus_data holds between beats
//   pending               : FIFO occupancy
//   grant_err             : sticky, grant seen while not requesting
//   timeout_err           : sticky, request waited TIMEOUT cycles
// Build option:
//   ARB_REQ_TIMEOUT_EN    : when defined, adds the request wait counter that
//                           drives timeout_err; otherwise timeout_err is 0.
// -----------------------------------------------------------------------------
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       req,
    input  logic                       grant,
    output logic                       bus_valid,
    output logic [DATA_W-1:0]          bus_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       grant_err,
    output logic                       timeout_err
);

    arb_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              bus_valid_q, bus_valid_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic              grant_err_q, grant_err_d;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    arb_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending)
    );

    assign in_ready  = ~fifo_full;
    assign req       = req_q;
    assign bus_valid = bus_valid_q;
    assign bus_data  = bus_data_q;
    assign grant_err = grant_err_q;

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        // A grant outside REQ is never acted upon, only recorded.
        grant_err_d = grant_err_q | (grant & (state_q != ST_REQ));
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    state_d  = ST_XFER;
                    fifo_pop = 1'b1;
                end
            end
            ST_XFER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // req is a flop copy of the next state so it lines up with state_q.
        req_d       = (state_d == ST_REQ);
        bus_valid_d = fifo_pop;
        bus_data_d  = fifo_pop ? fifo_head : bus_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            grant_err_q <= grant_err_d;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_err_q, timeout_err_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        // Restart on each new request; saturate so the count never wraps.
        if ((state_q != ST_REQ) && (state_d == ST_REQ)) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_REQ) && (wait_cnt_q != TW'(TIMEOUT))) begin
            wait_cnt_d = wait_cnt_q + TW'(1);
        end
        timeout_err_d = timeout_err_q | (wait_cnt_d == TW'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        req;
    logic        grant;
    logic        bus_valid;
    logic [31:0] bus_data;
    logic [2:0]  pending;
    logic        grant_err;
    logic        timeout_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    bit          gnt_en = 1'b0;
    bit          manual = 1'b0;
    logic        exp_to;

    always #5 clk = ~clk;

    arb_requester #(
        .DATA_W  (32),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .req         (req),
        .grant       (grant),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .pending     (pending),
        .grant_err   (grant_err),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Arbiter model: registered grant, one cycle after req has been seen high.
    initial begin
        logic r;
        grant = 1'b0;
        forever begin
            @(posedge clk);
            r = req;
            #1;
            if (!manual) grant = gnt_en && r && req && !grant;
        end
    end

    // Monitor: every beat must match the oldest expected payload.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL beat_unexpected: got %0h, expected no beat", bus_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus_data !== e) begin
                        n_err++;
                        $display("FAIL beat_data: got %0h, expected %0h", bus_data, e);
                    end
                end
            end
        end
    end

    task automatic push(input logic [31:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        if (in_ready) exp_q.push_back(d);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef ARB_REQ_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_req", req, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_data", bus_data, 0);
        chk("rst_pending", pending, 0);
        chk("rst_grant_err", grant_err, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        // Single transaction latency
        gnt_en = 1'b1;
        push(32'hA5A5_0001);
        @(negedge clk);
        chk("t1_pending_1", pending, 1);
        chk("t1_req_low", req, 0);
        @(negedge clk);
        chk("t1_req_high", req, 1);
        @(negedge clk);
        chk("t1_grant", grant, 1);
        chk("t1_no_beat_yet", bus_valid, 0);
        @(negedge clk);
        chk("t1_beat", bus_valid, 1);
        chk("t1_pending_0", pending, 0);
        @(negedge clk);
        chk("t1_beat_one_cycle", bus_valid, 0);
        chk("t1_req_after", req, 0);
        chk("t1_data_hold", bus_data, 32'hA5A5_0001);
        wait_drain(10);

        // Fill to full with grant withheld, then drain in order
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h10 + i);
        @(negedge clk);
        chk("t2_full_ready", in_ready, 0);
        chk("t2_full_pending", pending, 4);
        in_valid = 1'b1;
        in_data  = 32'h14;
        chk("t2_fifth_ready", in_ready, 0);
        if (in_ready) exp_q.push_back(32'h14);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t2_fifth_rejected", pending, 4);
        repeat (20) @(negedge clk);
        chk("t2_req_held", req, 1);
        chk("t2_timeout_err", timeout_err, exp_to);
        gnt_en = 1'b1;
        wait_drain(100);
        repeat (3) @(negedge clk);
        chk("t2_pending_0", pending, 0);
        chk("t2_no_grant_err", grant_err, 0);

        // Stray grant while idle
        gnt_en = 1'b0;
        repeat (3) @(negedge clk);
        manual = 1'b1;
        grant  = 1'b1;
        @(posedge clk);
        #1 grant = 1'b0;
        manual = 1'b0;
        @(negedge clk);
        chk("t3_grant_err", grant_err, 1);
        chk("t3_no_beat", bus_valid, 0);
        chk("t3_pending", pending, 0);
        repeat (5) @(negedge clk);
        chk("t3_grant_err_sticky", grant_err, 1);

        // Reset in the middle of a request
        for (int i = 0; i < 3; i++) push(32'hB0 + i);
        @(negedge clk);
        chk("t4_pending_3", pending, 3);
        chk("t4_req", req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_req", req, 0);
        chk("t4_rst_pending", pending, 0);
        chk("t4_rst_bus_valid", bus_valid, 0);
        chk("t4_rst_grant_err", grant_err, 0);
        chk("t4_rst_timeout_err", timeout_err, 0);
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        gnt_en = 1'b1;
        @(negedge clk);
        chk("t4_rel_in_ready", in_ready, 1);
        repeat (10) @(negedge clk);
        chk("t4_req_idle", req, 0);
        chk("t4_pending_idle", pending, 0);

        // Streaming with grants enabled: pushes overlap pops
        for (int i = 0; i < 8; i++) push(32'h20 + i);
        wait_drain(200);
        repeat (3) @(negedge clk);
        chk("t5_pending_0", pending, 0);
        chk("t5_no_grant_err", grant_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DATA_W, default 32, width of transaction payload.
REQ-002 Parameter DEPTH, default 4, pending-transaction FIFO entries (power of 2, >=2).
REQ-003 Parameter TIMEOUT, default 16, cycles a request may wait for grant before flagging.
REQ-004 clk  input  1  rising-edge clock; sole clock domain.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  local producer offers a transaction.
REQ-007 in_data  input  DATA_W  transaction payload.
REQ-008 in_ready  output  1  FIFO can accept; transfer when in_valid & in_ready.
REQ-009 req  output  1  registered request line to one port of the round-robin arbiter.
REQ-010 grant  input  1  single-cycle registered grant pulse from the arbiter.
REQ-011 bus_valid  output  1  registered one-cycle beat onto the shared bus.
REQ-012 bus_data  output  DATA_W  payload of the beat; holds last value when bus_valid low.
REQ-013 pending  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-014 grant_err  output  1  sticky: grant seen while not requesting.
REQ-015 timeout_err  output  1  sticky: request waited TIMEOUT cycles (see Configuration).

Function
REQ-016 FSM states IDLE, REQ, XFER; registered state, one transition per clock.
REQ-017 IDLE -> REQ when FIFO non-empty; else stay IDLE.
REQ-018 REQ -> XFER on cycle grant sampled high; else stay REQ (req held, never withdrawn).
REQ-019 XFER -> IDLE unconditionally after one cycle; req low in XFER and IDLE, giving >=2 req-low cycles between requests.
REQ-020 req = 1 exactly while state==REQ.
REQ-021 On REQ->XFER edge: FIFO head popped, bus_valid=1 and bus_data=head for exactly the XFER cycle.
REQ-022 Latency: push into empty FIFO at edge t -> req high after edge t+1; grant high in cycle g -> bus_valid high in cycle g+1.
REQ-023 One beat per grant; FIFO order preserved (first in, first out).
REQ-024 in_ready = (pending != DEPTH); push when full impossible; same-cycle push and pop allowed at any non-full occupancy, pending unchanged.
REQ-025 pending wraps never; pointers wrap modulo DEPTH.
REQ-026 grant high in IDLE or XFER: ignored (no pop, no beat), grant_err set and held until reset.

Reset
REQ-027 rst_n low: state=IDLE, FIFO emptied, pending=0, req=0, bus_valid=0, bus_data=0, grant_err=0, timeout_err=0, wait counter=0.
REQ-028 Reset mid-request or mid-transfer discards all queued and in-flight transactions; no beat issued after release until a new push.
REQ-029 in_ready=1 first cycle after reset release.

Configuration
REQ-030 Macro ARB_REQ_TIMEOUT_EN defined: counter clears on entering REQ, increments each REQ cycle, saturates; reaching TIMEOUT sets timeout_err sticky; req remains asserted.
REQ-031 Macro undefined: no counter logic; timeout_err tied 0; port list unchanged.

Structure
REQ-032 Shared package arb_pkg holds state enum type and default constants for DATA_W, DEPTH, TIMEOUT.
REQ-033 Sub-module arb_req_fifo (synchronous FIFO, push/pop/full/empty/count); FSM and error logic in arb_requester.

Verification
REQ-034 Reset, push 0xA5A5_0001; grant 1 cycle after req rises -> req high 1 cycle later than push edge, bus_valid one cycle with 0xA5A5_0001, pending 1->0.
REQ-035 Push 4 items (0x10..0x13) back-to-back with grant withheld -> in_ready low at pending=4, 5th in_valid not accepted; four grants -> beats 0x10,0x11,0x12,0x13 in order.
REQ-036 Grant pulse while IDLE with empty FIFO -> no beat, grant_err=1 and stays 1 until rst_n low.
REQ-037 With ARB_REQ_TIMEOUT_EN, hold grant low 16 cycles in REQ -> timeout_err=1, req still 1; subsequent grant -> normal beat. Without macro -> timeout_err stays 0.
REQ-038 Assert rst_n low in REQ with pending=3 -> req=0, pending=0, bus_valid=0 immediately; after release no beat without new push.
REQ-039 Two instances on ports 0 and 1 of the 4-port round-robin arbiter, both continuously loaded -> grants alternate, each beat accepted, no grant_err.
